// File: rtl/effect_ram_arbiter.sv
// Round-robin arbiter between the effect engine (req0) and the sample/control streamer (req1)
// for the single-port effect register RAM; generates the RAM clock/strobe sequence itself.
module effect_ram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  input  logic [DATA_W-1:0] loc_readdata,
  output logic [DATA_W-1:0] loc_writedata,
  output logic [ADDR_W-1:0] loc_ramaddress,
  output logic              loc_ramclk,
  output logic              loc_ramread,
  output logic              loc_ramwrite
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                gnt_q, gnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                win1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // On a tie the requester that was not granted last time wins.
  assign win1 = req1_valid && (!req0_valid || !last_grant_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    req0_done    = 1'b0;
    req1_done    = 1'b0;
    loc_ramclk   = 1'b0;
    loc_ramread  = 1'b0;
    loc_ramwrite = 1'b0;

    case (state_q)
      IDLE: begin
        if (reset && (req0_valid || req1_valid)) begin
          req0_ready   = !win1;
          req1_ready   = win1;
          gnt_d        = win1;
          last_grant_d = win1;
          write_d      = win1 ? req1_write : req0_write;
          addr_d       = win1 ? req1_addr  : req0_addr;
          wdata_d      = win1 ? req1_wdata : req0_wdata;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        loc_ramwrite = write_q;
        loc_ramread  = !write_q;
        state_d      = STROBE;
      end
      STROBE: begin
        loc_ramclk   = 1'b1;
        loc_ramwrite = write_q;
        loc_ramread  = !write_q;
        if (!write_q) begin
          if (gnt_q) rdata1_d = loc_readdata;
          else       rdata0_d = loc_readdata;
        end
        state_d = RELEASE;
      end
      RELEASE: begin
        req0_done = !gnt_q;
        req1_done = gnt_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign loc_ramaddress = addr_q;
  assign loc_writedata  = wdata_q;
  assign req0_rdata     = rdata0_q;
  assign req1_rdata     = rdata1_q;

endmodule

// File: tb/tb_effect_ram_arbiter.sv
// Self-checking bench for effect_ram_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-budget reference model of the arbitration and RAM contents.
module tb_effect_ram_arbiter;

  typedef struct packed {
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } op_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_write, req0_ready, req0_done;
  logic [4:0]  req0_addr;
  logic [31:0] req0_wdata, req0_rdata;
  logic        req1_valid, req1_write, req1_ready, req1_done;
  logic [4:0]  req1_addr;
  logic [31:0] req1_wdata, req1_rdata;
  logic [31:0] loc_readdata, loc_writedata;
  logic [4:0]  loc_ramaddress;
  logic        loc_ramclk, loc_ramread, loc_ramwrite;

  always #5 clk = ~clk;

  effect_ram_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
    .req1_rdata(req1_rdata),
    .loc_readdata(loc_readdata), .loc_writedata(loc_writedata),
    .loc_ramaddress(loc_ramaddress), .loc_ramclk(loc_ramclk),
    .loc_ramread(loc_ramread), .loc_ramwrite(loc_ramwrite)
  );

  // RAM model clocked by the arbiter's generated clock; preload port used only under reset.
  logic [31:0] ram [32];
  logic        preload_go = 1'b0;
  logic [4:0]  preload_addr;
  logic [31:0] preload_data;

  always @(posedge loc_ramclk or posedge preload_go) begin
    if (preload_go) ram[preload_addr] <= preload_data;
    else begin
      if (loc_ramwrite) ram[loc_ramaddress] <= loc_writedata;
      if (loc_ramread)  loc_readdata <= ram[loc_ramaddress];
    end
  end

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          busy_until = 0;
  int          gate = 0;
  logic        last_m = 1'b1;
  logic [31:0] mem_m [32];
  logic [31:0] rdata_exp [2];
  logic        act_valid = 1'b0;
  logic        act_id, act_write;
  int          act_cyc;
  logic [4:0]  act_addr;
  logic [31:0] act_wdata, act_rdata;
  op_t         q0[$], q1[$];
  logic        pres0 = 1'b0, pres1 = 1'b0;
  int          grant_id_log[$], grant_cyc_log[$];
  logic [31:0] wd_log[$];
  logic [31:0] b2b_data [3];

  function automatic op_t mkop(input logic w, input logic [4:0] a, input logic [31:0] d);
    op_t o;
    o.write = w; o.addr = a; o.wdata = d;
    return o;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Mid-cycle: predict who may be accepted from valids, last winner and the 4-cycle budget.
  task automatic sampleHandshake();
    int win;
    win = -1;
    if (reset && cyc >= busy_until) begin
      if (req0_valid && req1_valid) win = last_m ? 0 : 1;
      else if (req0_valid) win = 0;
      else if (req1_valid) win = 1;
    end
    checkOutput("ready0", 32'(req0_ready), 32'(win == 0));
    checkOutput("ready1", 32'(req1_ready), 32'(win == 1));
    if (win >= 0) begin
      act_valid = 1'b1;
      act_id    = (win == 1);
      act_cyc   = cyc;
      act_write = (win == 1) ? req1_write : req0_write;
      act_addr  = (win == 1) ? req1_addr  : req0_addr;
      act_wdata = (win == 1) ? req1_wdata : req0_wdata;
      act_rdata = mem_m[act_addr];
      if (act_write) mem_m[act_addr] = act_wdata;
      last_m     = (win == 1);
      busy_until = cyc + 4;
    end
    if (req0_valid && req0_ready) begin
      grant_id_log.push_back(0); grant_cyc_log.push_back(cyc);
      if (q0.size() > 0) void'(q0.pop_front());
      pres0 = 1'b0;
    end
    if (req1_valid && req1_ready) begin
      grant_id_log.push_back(1); grant_cyc_log.push_back(cyc);
      if (q1.size() > 0) void'(q1.pop_front());
      pres1 = 1'b0;
    end
  endtask

  // After each edge: RAM strobes, done pulses and rdata against the in-flight access.
  task automatic checkCycle();
    int d;
    d = cyc - act_cyc;
    checkOutput("ramclk", 32'(loc_ramclk), 32'(act_valid && d == 2));
    checkOutput("ramwrite", 32'(loc_ramwrite), 32'(act_valid && (d == 1 || d == 2) && act_write));
    checkOutput("ramread", 32'(loc_ramread), 32'(act_valid && (d == 1 || d == 2) && !act_write));
    if (act_valid && (d == 1 || d == 2)) begin
      checkOutput("ramaddress", 32'(loc_ramaddress), 32'(act_addr));
      if (act_write) checkOutput("writedata", loc_writedata, act_wdata);
    end
    if (loc_ramclk) wd_log.push_back(loc_writedata);
    checkOutput("done0", 32'(req0_done), 32'(act_valid && d == 3 && act_id == 1'b0));
    checkOutput("done1", 32'(req1_done), 32'(act_valid && d == 3 && act_id == 1'b1));
    if (act_valid && d == 3) begin
      if (!act_write) rdata_exp[act_id] = act_rdata;
      act_valid = 1'b0;
    end
    checkOutput("rdata0", req0_rdata, rdata_exp[0]);
    checkOutput("rdata1", req1_rdata, rdata_exp[1]);
  endtask

  // Requests are held stable from first presentation until accepted; junk while idle.
  task automatic applyStimulus();
    if (!pres0 && q0.size() > 0 && $urandom_range(99) >= 32'(gate)) pres0 = 1'b1;
    if (!pres1 && q1.size() > 0 && $urandom_range(99) >= 32'(gate)) pres1 = 1'b1;
    req0_valid = pres0;
    req1_valid = pres1;
    if (pres0) {req0_write, req0_addr, req0_wdata} = q0[0];
    else {req0_write, req0_addr, req0_wdata} = {1'($urandom), 5'($urandom), 32'($urandom)};
    if (pres1) {req1_write, req1_addr, req1_wdata} = q1[0];
    else {req1_write, req1_addr, req1_wdata} = {1'($urandom), 5'($urandom), 32'($urandom)};
  endtask

  task automatic tick();
    @(negedge clk);
    sampleHandshake();
    @(posedge clk);
    #1;
    cyc++;
    checkCycle();
    applyStimulus();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || pres0 || pres1 || cyc < busy_until) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) checkOutput("drain_timeout", 32'(n), 32'd0);
  endtask

  task automatic clearLogs();
    grant_id_log.delete(); grant_cyc_log.delete(); wd_log.delete();
  endtask

  task automatic checkSpacing(input string tag, input int expected_n);
    checkOutput({tag, "_count"}, 32'(grant_id_log.size()), 32'(expected_n));
    for (int i = 1; i < grant_cyc_log.size(); i++)
      checkOutput({tag, "_spacing"}, 32'(grant_cyc_log[i] - grant_cyc_log[i-1]), 32'd4);
  endtask

  initial begin
    reset = 1'b0;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
    rdata_exp[0] = '0; rdata_exp[1] = '0;

    for (int i = 0; i < 32; i++) begin
      preload_addr = 5'(i);
      preload_data = (i == 2) ? 32'h1234_5678 : $urandom;
      mem_m[i] = preload_data;
      preload_go = 1'b1; #1; preload_go = 1'b0; #1;
    end

    $display("[TB] reset check");
    repeat (3) tick();
    checkOutput("rst_ramaddress", 32'(loc_ramaddress), 32'd0);
    checkOutput("rst_writedata", loc_writedata, 32'd0);
    checkOutput("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    reset = 1'b1;
    repeat (4) tick();

    $display("[TB] single write then read-back");
    gate = 0;
    clearLogs();
    q0.push_back(mkop(1'b1, 5'd5, 32'h0000_ABCD));
    drain();
    checkOutput("wr_grant_count", 32'(grant_id_log.size()), 32'd1);
    if (grant_id_log.size() > 0) checkOutput("wr_grant_id", 32'(grant_id_log[0]), 32'd0);
    q0.push_back(mkop(1'b0, 5'd5, 32'h0));
    drain();
    checkOutput("readback", req0_rdata, 32'h0000_ABCD);

    $display("[TB] single read by requester 1");
    q1.push_back(mkop(1'b0, 5'd2, 32'h0));
    drain();
    checkOutput("read1", req1_rdata, 32'h1234_5678);

    $display("[TB] fair tie-break");
    clearLogs();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mkop(1'b0, 5'($urandom), 32'h0));
      q1.push_back(mkop(1'b0, 5'($urandom), 32'h0));
    end
    drain();
    checkSpacing("tie", 8);
    for (int i = 0; i < grant_id_log.size() && i < 8; i++)
      checkOutput("tie_id", 32'(grant_id_log[i]), 32'(i % 2));

    $display("[TB] back-to-back writes");
    clearLogs();
    for (int i = 0; i < 3; i++) begin
      b2b_data[i] = $urandom;
      q0.push_back(mkop(1'b1, 5'(10 + i), b2b_data[i]));
    end
    drain();
    checkSpacing("b2b", 3);
    checkOutput("b2b_wd_count", 32'(wd_log.size()), 32'd3);
    for (int i = 0; i < wd_log.size() && i < 3; i++)
      checkOutput("b2b_wd_order", wd_log[i], b2b_data[i]);

    $display("[TB] randomized traffic");
    gate = 40;
    for (int i = 0; i < 30; i++) begin
      q0.push_back(mkop(1'($urandom), 5'($urandom), $urandom));
      q1.push_back(mkop(1'($urandom), 5'($urandom), $urandom));
    end
    drain();

    $display("[TB] reset during strobe");
    gate = 0;
    q1.push_back(mkop(1'b1, 5'd9, $urandom));
    begin
      int n;
      n = 0;
      while (!(act_valid && act_id && (cyc - act_cyc) == 2) && n < 20) begin
        tick();
        n++;
      end
      if (n >= 20) checkOutput("strobe_timeout", 32'(n), 32'd0);
    end
    checkOutput("pre_rst_ramclk", 32'(loc_ramclk), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("midrst_ramclk", 32'(loc_ramclk), 32'd0);
    checkOutput("midrst_ramwrite", 32'(loc_ramwrite), 32'd0);
    checkOutput("midrst_ramread", 32'(loc_ramread), 32'd0);
    act_valid = 1'b0; last_m = 1'b1; busy_until = 0;
    rdata_exp[0] = '0; rdata_exp[1] = '0;
    q0.delete(); q1.delete(); pres0 = 1'b0; pres1 = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    clearLogs();
    q0.push_back(mkop(1'b0, 5'd9, 32'h0));
    q1.push_back(mkop(1'b0, 5'd3, 32'h0));
    drain();
    checkOutput("post_rst_count", 32'(grant_id_log.size()), 32'd2);
    if (grant_id_log.size() > 0) checkOutput("post_rst_first", 32'(grant_id_log[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/effect_ram_arbiter.md
# effect_ram_arbiter

Two-requester arbiter for the single-port 32×32 effect register RAM (select-effect, distortion gain/boost, input, read-finish, output, ready-to-get words). It sits between the RAM's bit-banged port and two clients:

- the effect engine (requester 0);
- the sample/control streamer (requester 1).

It serialises their accesses with round-robin fairness and generates the RAM clock/strobe sequence so neither client drives the RAM directly.

## Interface
Parameters:
- ADDR_W, 5, RAM word-address width
- DATA_W, 32, RAM data width

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low
- req0_valid / req1_valid  in  1  access request, held until accepted
- req0_write / req1_write  in  1  1 = write, 0 = read; qualified by valid
- req0_addr / req1_addr  in  ADDR_W  word address
- req0_wdata / req1_wdata  in  DATA_W  write data
- req0_ready / req1_ready  out  1  combinational accept; transfer when valid & ready
- req0_done / req1_done  out  1  one-cycle completion pulse (reads and writes)
- req0_rdata / req1_rdata  out  DATA_W  read data; valid in the done cycle of a read, held until the next read completes for that requester
- loc_readdata  in  DATA_W  RAM read data
- loc_writedata  out  DATA_W  RAM write data
- loc_ramaddress  out  ADDR_W  RAM address
- loc_ramclk  out  1  RAM clock, generated by the arbiter
- loc_ramread  out  1  RAM read enable
- loc_ramwrite  out  1  RAM write enable

## Operation
- FSM: IDLE → SETUP → STROBE → RELEASE → IDLE.
- **IDLE**
  - ready is asserted only in IDLE, to at most one requester.
  - On accept, latch addr, wdata, write and grant id.
  - Set last_grant to the granted id; go to SETUP.
- **SETUP**
  - loc_ramclk=0.
  - Drive loc_ramaddress and loc_writedata from the latch.
  - loc_ramwrite = write; loc_ramread = ~write.
- **STROBE**
  - loc_ramclk=1; address, data and enables held.
  - For reads, capture loc_readdata into the granted requester's rdata register on the edge leaving STROBE.
- **RELEASE**
  - loc_ramclk=0; loc_ramwrite=0, loc_ramread=0.
  - Pulse done for the granted requester; return to IDLE.
- **Arbitration**
  - Only one valid: that requester wins.
  - Both valid: the requester ≠ last_grant wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
- **Holding rules**
  - Non-granted requests stay pending with ready=0; there is no drop and no timeout.
  - A requester's request is stable after accept; it may present the next request immediately. That request waits until IDLE.
- **Reset values**
  - All RAM outputs 0, loc_ramclk 0, loc_writedata 0, loc_ramaddress 0.
  - ready 0, done 0, rdata 0, last_grant 1, state IDLE.
- **Reset mid-access:** the transaction is abandoned; no done pulse is issued; the RAM strobes return to 0 asynchronously.
- **Address width:** addresses wrap naturally within ADDR_W. No range check is performed; all 32 words are accessible to both requesters.

## Timing
- Accept in cycle T (IDLE, valid & ready). Then:
  - SETUP in T+1;
  - loc_ramclk high in T+2;
  - done and rdata in T+3;
  - earliest next accept in T+4.
- Throughput is one access per 4 cycles. Worst-case wait for a continuously asserted request is 4 cycles.
- loc_ramaddress, loc_writedata and the enables are stable from T+1 through T+2, so they are stable across the loc_ramclk rising edge.
- done is exactly one cycle wide. done is never asserted for both requesters in the same cycle.
- ready is never asserted outside IDLE. ready is never asserted for both requesters in the same cycle.

## Test plan
- **Reset check:** assert reset for 3 cycles → all outputs 0. Release, no requests → loc_ramclk stays 0 and the state remains IDLE.
- **Single write:** req0 writes 0x0000_ABCD to addr 5 → loc_ramwrite=1, loc_ramaddress=5 in T+1..T+2, loc_ramclk=1 only in T+2, req0_done in T+3. A subsequent read of addr 5 returns 0x0000_ABCD.
- **Single read:** req1 reads addr 2 with the RAM model holding 0x1234_5678 → loc_ramread=1 in T+1..T+2, req1_done and req1_rdata=0x1234_5678 in T+3, req0_done stays 0.
- **Fair tie-break:** both valid continuously from reset, each doing 4 reads → grants are 0,1,0,1,0,1,0,1, with accepts spaced 4 cycles apart.
- **Back-to-back:** req0 alone issues 3 writes with valid held high → accepts at T, T+4, T+8; each write appears on loc_writedata in the correct order.
- **Reset mid-operation:** assert reset during STROBE of a req1 write → loc_ramclk, loc_ramwrite and loc_ramread go to 0 immediately and no req1_done is produced. After release, the first tie is granted to requester 0.
